alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised sequential ALU for the MiniRISC CPU datapath. It extends the single-cycle ALU with a configurable data width and a registered result. It adds an iterative multiplier and an optional iterative divider, with a start/busy/done handshake that lets the control unit stall on multi-cycle operations. Z/C/N/V flags keep their interrupt save/restore write port.

## Interface
- `DATA_W`, default 8: operand/result width; even, ≥ 4.
- `clk`  in  1: clock, all state on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: operation request; sampled only when `busy`=0.
- `op_type`  in  3: 000 MOVE, 001 ARITH, 010 LOGIC, 011 SHIFT, 100 MUL, 101 DIV, 11x reserved.
- `arith_sel`  in  2: bit1 = subtract, bit0 = use carry.
- `logic_sel`  in  2: 00 AND, 01 OR, 10 XOR, 11 swap halves of operand1.
- `shift_sel`  in  4: [1:0] 00 SHL, 01 SHR, 10 ROL, 11 ROR; bit2 = shift-in 1 / rotate through C; bit3 = arithmetic SHR.
- `operand1`, `operand2`  in  DATA_W: operands (multiplicand/dividend = op1).
- `result`  out  DATA_W: registered result (MUL low half, DIV quotient).
- `result_hi`  out  DATA_W: MUL high half, DIV remainder, 0 otherwise.
- `busy`  out  1: multi-cycle operation in progress.
- `done`  out  1: one-cycle pulse; `result`/`result_hi`/flags valid from this cycle.
- `flag_din`  in  4: flag write value, bit0 Z, bit1 C, bit2 N, bit3 V.
- `flag_wr`  in  1: flag write enable.
- `flag_z`, `flag_c`, `flag_n`, `flag_v`  out  1 each: flags.

## Operation
- Operands and selects are captured at accepted `start`; later input changes do not affect the operation.
- **MOVE**: `result` = op2. Flags unchanged.
- **ARITH**
  - Sum = op1 + (op2 ^ {sub}) + cin, where cin = use_carry ? (C ^ sub) : sub.
  - C = carry-out ^ sub.
  - V is set when both addends have the same sign and the sum sign differs.
  - Z and N are taken from the result.
- **LOGIC**: result per `logic_sel`. Z and N are updated; C and V are unchanged.
- **SHIFT**
  - C = the bit shifted out.
  - SHL shifts in bit2. SHR shifts in the MSB when bit3=1, otherwise bit2. ROL/ROR rotate in C when bit2=1, otherwise the exiting bit.
  - Z and N are updated; V is unchanged.
- **MUL**
  - Unsigned shift-add, one partial product per cycle, DATA_W iterations; {result_hi, result} = op1·op2.
  - Z = (2·DATA_W product == 0), N = product MSB, C = V = (result_hi ≠ 0).
- **DIV**
  - Unsigned restoring division, one quotient bit per cycle, DATA_W iterations.
  - Z = (quotient == 0), N = quotient MSB, C = 0, V = 0.
  - op2 = 0: result = all ones, result_hi = op1, V = 1, C = 0, Z = 0, N = 1; full latency still applies.
- **Reserved op_type**: result = result_hi = 0, flags unchanged, `done` pulses.
- **FSM**: IDLE → MUL or DIV on accepted start; stays IDLE for single-cycle ops. Returns to IDLE when the iteration counter reaches DATA_W−1.
- `start` while `busy`=1 is ignored, with no queuing.
- Flags are loaded at the `done` edge. A `flag_wr` in the same cycle takes priority over the operation's flag update. `flag_wr` during `busy` writes immediately.

## Timing
- Reset values: result = 0, result_hi = 0, busy = 0, done = 0, all flags 0, FSM IDLE, counter 0.
- Single-cycle ops: start accepted at edge T → `done`=1 and results valid in cycle T+1; `busy` stays 0.
- MUL/DIV: start at edge T → `busy`=1 in cycles T+1..T+DATA_W, `done`=1 in cycle T+DATA_W+1 with `busy`=0.
- A new start may be accepted in the `done` cycle (back-to-back ops).
- `result`/`result_hi` hold their values until the next `done`. Intermediate iteration state is internal and never visible on the outputs.
- `rst_n` low mid-operation aborts immediately: busy = 0, no `done`, all outputs return to reset values.

## Configuration
- `ALU_SEQ_DIV_EN` defined: divider datapath and DIV state compiled in.
- `ALU_SEQ_DIV_EN` undefined: op_type 101 is handled as reserved (done at T+1, zero results, flags unchanged), and no divider logic is synthesised.

## Test plan
- ADD, DATA_W=8, op1=0x7F, op2=0x01 → result 0x80, N=1, V=1, C=0, Z=0, `done` at T+1, `busy` never high.
- SUB with carry, C=1 preset via `flag_wr`, op1=0x10, op2=0x10 → result 0xFF, C=1, N=1, Z=0.
- MUL 0xFF×0xFF → result_hi 0xFE, result 0x01, C=V=1, `busy` for 8 cycles, `done` at T+9; a `start` at T+3 with op ADD is ignored.
- DIV (ALU_SEQ_DIV_EN) 200/7 → quotient 0x1C, remainder 0x04, V=0. Then 200/0 → 0xFF, remainder 0xC8, V=1, `done` at T+9.
- `flag_wr`=1 with flag_din=4'b0101 in the MUL `done` cycle → flags Z=1, N=1, C=0, V=0.
- `rst_n` pulsed low at T+4 of MUL → busy 0 and no `done`; a following MOVE of 0x5A → result 0x5A at T+1, flags unchanged.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequential MiniRISC ALU with registered result, iterative multiplier and
// optional iterative divider (compile with ALU_SEQ_DIV_EN defined to include DIV).
module alu_seq #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op_type,
  input  logic [1:0]        arith_sel,
  input  logic [1:0]        logic_sel,
  input  logic [3:0]        shift_sel,
  input  logic [DATA_W-1:0] operand1,
  input  logic [DATA_W-1:0] operand2,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] result_hi,
  output logic              busy,
  output logic              done,
  input  logic [3:0]        flag_din,
  input  logic              flag_wr,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_n,
  output logic              flag_v
);

  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [2:0] OP_MOVE  = 3'b000;
  localparam logic [2:0] OP_ARITH = 3'b001;
  localparam logic [2:0] OP_LOGIC = 3'b010;
  localparam logic [2:0] OP_SHIFT = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [2:0] OP_DIV   = 3'b101;
`endif

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL
`ifdef ALU_SEQ_DIV_EN
    , S_DIV
`endif
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic              last;
  logic [3:0]        flags;

  // Shared iteration registers: acc_hi is the product high half or the partial
  // remainder, acc_lo the multiplier or the dividend/quotient, opnd_b the
  // multiplicand or divisor.
  logic [DATA_W-1:0] acc_hi, acc_lo, opnd_b;

  logic [DATA_W-1:0] sc_result;
  logic [3:0]        sc_flags;
  logic [DATA_W-1:0] addend;
  logic              cin;
  logic [DATA_W:0]   sum;
  logic              sh_in, sh_out;

  logic [DATA_W:0]   mul_sum;
  logic [DATA_W-1:0] mul_hi_nxt, mul_lo_nxt;

  logic              fin_valid;
  logic [DATA_W-1:0] fin_result, fin_result_hi;
  logic              fin_flag_we;
  logic [3:0]        fin_flags;
  logic              iter_load;

  assign {flag_v, flag_n, flag_c, flag_z} = flags;
  assign busy = (state != S_IDLE);
  assign last = (cnt == CNT_W'(DATA_W - 1));

  // Single-cycle operations, evaluated directly from the inputs at the start edge.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    sc_result = '0;
    sc_flags  = flags;
    addend    = '0;
    cin       = 1'b0;
    sum       = '0;
    sh_in     = 1'b0;
    sh_out    = 1'b0;
    case (op_type)
      OP_MOVE: sc_result = operand2;
      OP_ARITH: begin
        addend    = operand2 ^ {DATA_W{arith_sel[1]}};
        cin       = arith_sel[0] ? (flags[FLAG_C] ^ arith_sel[1]) : arith_sel[1];
        sum       = {1'b0, operand1} + {1'b0, addend} + {{DATA_W{1'b0}}, cin};
        sc_result = sum[DATA_W-1:0];
        sc_flags[FLAG_Z] = (sc_result == '0);
        sc_flags[FLAG_C] = sum[DATA_W] ^ arith_sel[1];
        sc_flags[FLAG_N] = sc_result[DATA_W-1];
        sc_flags[FLAG_V] = (operand1[DATA_W-1] == addend[DATA_W-1]) &&
                           (sc_result[DATA_W-1] != operand1[DATA_W-1]);
      end
      OP_LOGIC: begin
        case (logic_sel)
          2'b00:   sc_result = operand1 & operand2;
          2'b01:   sc_result = operand1 | operand2;
          2'b10:   sc_result = operand1 ^ operand2;
          default: sc_result = {operand1[DATA_W/2-1:0], operand1[DATA_W-1:DATA_W/2]};
        endcase
        sc_flags[FLAG_Z] = (sc_result == '0);
        sc_flags[FLAG_N] = sc_result[DATA_W-1];
      end
      OP_SHIFT: begin
        case (shift_sel[1:0])
          2'b00: begin
            sh_out    = operand1[DATA_W-1];
            sh_in     = shift_sel[2];
            sc_result = {operand1[DATA_W-2:0], sh_in};
          end
          2'b01: begin
            sh_out    = operand1[0];
            sh_in     = shift_sel[3] ? operand1[DATA_W-1] : shift_sel[2];
            sc_result = {sh_in, operand1[DATA_W-1:1]};
          end
          2'b10: begin
            sh_out    = operand1[DATA_W-1];
            sh_in     = shift_sel[2] ? flags[FLAG_C] : operand1[DATA_W-1];
            sc_result = {operand1[DATA_W-2:0], sh_in};
          end
          default: begin
            sh_out    = operand1[0];
            sh_in     = shift_sel[2] ? flags[FLAG_C] : operand1[0];
            sc_result = {sh_in, operand1[DATA_W-1:1]};
          end
        endcase
        sc_flags[FLAG_Z] = (sc_result == '0);
        sc_flags[FLAG_C] = sh_out;
        sc_flags[FLAG_N] = sc_result[DATA_W-1];
      end
      default: ;  // reserved (and DIV when not compiled in): zero result, flags kept
    endcase
  end

  // One shift-add step: add the multiplicand when the current multiplier bit is set,
  // then shift the {acc_hi, acc_lo} pair right by one.
  assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : {(DATA_W+1){1'b0}});
  assign mul_hi_nxt = mul_sum[DATA_W:1];
  assign mul_lo_nxt = {mul_sum[0], acc_lo[DATA_W-1:1]};

`ifdef ALU_SEQ_DIV_EN
  logic [DATA_W:0]   div_shift, div_trial;
  logic              div_fit;
  logic [DATA_W-1:0] div_rem_nxt, div_quo_nxt;

  // One restoring step. A zero divisor always fits, which naturally yields an
  // all-ones quotient and the dividend as remainder.
  assign div_shift   = {acc_hi, acc_lo[DATA_W-1]};
  assign div_trial   = div_shift - {1'b0, opnd_b};
  assign div_fit     = ~div_trial[DATA_W];
  assign div_rem_nxt = div_fit ? div_trial[DATA_W-1:0] : div_shift[DATA_W-1:0];
  assign div_quo_nxt = {acc_lo[DATA_W-2:0], div_fit};
`endif

  // Control FSM: next state and the values committed at the done edge.
  always_comb begin
    state_nxt     = state;
    fin_valid     = 1'b0;
    fin_result    = '0;
    fin_result_hi = '0;
    fin_flag_we   = 1'b0;
    fin_flags     = flags;
    iter_load     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (op_type == OP_MUL) begin
            state_nxt = S_MUL;
            iter_load = 1'b1;
          end
`ifdef ALU_SEQ_DIV_EN
          else if (op_type == OP_DIV) begin
            state_nxt = S_DIV;
            iter_load = 1'b1;
          end
`endif
          else begin
            fin_valid   = 1'b1;
            fin_result  = sc_result;
            fin_flag_we = 1'b1;
            fin_flags   = sc_flags;
          end
        end
      end
      S_MUL: begin
        if (last) begin
          state_nxt         = S_IDLE;
          fin_valid         = 1'b1;
          fin_result        = mul_lo_nxt;
          fin_result_hi     = mul_hi_nxt;
          fin_flag_we       = 1'b1;
          fin_flags[FLAG_Z] = ({mul_hi_nxt, mul_lo_nxt} == '0);
          fin_flags[FLAG_C] = (mul_hi_nxt != '0);
          fin_flags[FLAG_N] = mul_hi_nxt[DATA_W-1];
          fin_flags[FLAG_V] = (mul_hi_nxt != '0);
        end
      end
`ifdef ALU_SEQ_DIV_EN
      S_DIV: begin
        if (last) begin
          state_nxt     = S_IDLE;
          fin_valid     = 1'b1;
          fin_result    = div_quo_nxt;
          fin_result_hi = div_rem_nxt;
          fin_flag_we   = 1'b1;
          if (opnd_b == '0) begin
            fin_flags = 4'b1100;  // V=1, N=1, C=0, Z=0
          end else begin
            fin_flags[FLAG_Z] = (div_quo_nxt == '0);
            fin_flags[FLAG_C] = 1'b0;
            fin_flags[FLAG_N] = div_quo_nxt[DATA_W-1];
            fin_flags[FLAG_V] = 1'b0;
          end
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      result_hi <= '0;
      done      <= 1'b0;
      flags     <= '0;
      cnt       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opnd_b    <= '0;
    end else begin
      done <= fin_valid;
      if (fin_valid) begin
        result    <= fin_result;
        result_hi <= fin_result_hi;
      end
      // An explicit flag write wins over the operation's own update.
      if (flag_wr)          flags <= flag_din;
      else if (fin_flag_we) flags <= fin_flags;

      // MUL is commutative, so both multi-cycle ops load op1 into acc_lo and op2 into opnd_b.
      if (iter_load) begin
        acc_hi <= '0;
        acc_lo <= operand1;
        opnd_b <= operand2;
        cnt    <= '0;
      end else if (busy) begin
        cnt <= last ? '0 : cnt + CNT_W'(1);
        if (state == S_MUL) begin
          acc_hi <= mul_hi_nxt;
          acc_lo <= mul_lo_nxt;
        end
`ifdef ALU_SEQ_DIV_EN
        else if (state == S_DIV) begin
          acc_hi <= div_rem_nxt;
          acc_lo <= div_quo_nxt;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (DATA_W=8); DIV vectors are
// selected by ALU_SEQ_DIV_EN, otherwise DIV is checked as a reserved opcode.
module tb_alu_seq;

  localparam int W = 8;

  localparam logic [2:0] OP_MOVE  = 3'b000;
  localparam logic [2:0] OP_ARITH = 3'b001;
  localparam logic [2:0] OP_LOGIC = 3'b010;
  localparam logic [2:0] OP_SHIFT = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_DIV   = 3'b101;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op_type;
  logic [1:0]   arith_sel, logic_sel;
  logic [3:0]   shift_sel;
  logic [W-1:0] operand1, operand2;
  logic [W-1:0] result, result_hi;
  logic         busy, done;
  logic [3:0]   flag_din;
  logic         flag_wr;
  logic         flag_z, flag_c, flag_n, flag_v;

  int total = 0;
  int bad   = 0;

  alu_seq #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_type(op_type),
    .arith_sel(arith_sel), .logic_sel(logic_sel), .shift_sel(shift_sel),
    .operand1(operand1), .operand2(operand2), .result(result), .result_hi(result_hi),
    .busy(busy), .done(done), .flag_din(flag_din), .flag_wr(flag_wr),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Flags in flag_din order: {V, N, C, Z}.
  function automatic logic [3:0] flags_now();
    return {flag_v, flag_n, flag_c, flag_z};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge, then scrambles the operands so a
  // design that fails to capture them at start is caught.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] asel, input logic [1:0] lsel, input logic [3:0] ssel);
    op_type = op; operand1 = a; operand2 = b;
    arith_sel = asel; logic_sel = lsel; shift_sel = ssel;
    start = 1'b1;
    tick();
    start = 1'b0;
    operand1 = ~a;
    operand2 = ~b;
  endtask

  task automatic single(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [1:0] asel, input logic [1:0] lsel,
                        input logic [3:0] ssel, input logic [W-1:0] exp_res, input logic [3:0] exp_fl);
    issue(op, a, b, asel, lsel, ssel);
    check({tag, "/done"}, done, 1'b1);
    check({tag, "/busy"}, busy, 1'b0);
    check({tag, "/res"},  result, exp_res);
    check({tag, "/hi"},   result_hi, 8'h00);
    check({tag, "/flags"}, flags_now(), exp_fl);
  endtask

`ifdef ALU_SEQ_DIV_EN
  task automatic long_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_lo,
                         input logic [W-1:0] exp_hi, input logic [3:0] exp_fl);
    issue(op, a, b, 2'b00, 2'b00, 4'b0000);
    for (int k = 1; k <= W; k++) begin
      check({tag, "/busy"}, busy, 1'b1);
      check({tag, "/early_done"}, done, 1'b0);
      tick();
    end
    check({tag, "/done"}, done, 1'b1);
    check({tag, "/busy_end"}, busy, 1'b0);
    check({tag, "/res"}, result, exp_lo);
    check({tag, "/hi"}, result_hi, exp_hi);
    check({tag, "/flags"}, flags_now(), exp_fl);
  endtask
`endif

  initial begin
    logic [3:0] fl_after;
    logic       seen;
    rst_n = 1'b1; start = 1'b0; op_type = '0; arith_sel = '0; logic_sel = '0;
    shift_sel = '0; operand1 = '0; operand2 = '0; flag_din = '0; flag_wr = 1'b0;
    #2 rst_n = 1'b0;
    #15;
    check("rst/res", result, 8'h00);
    check("rst/hi", result_hi, 8'h00);
    check("rst/busy", busy, 1'b0);
    check("rst/done", done, 1'b0);
    check("rst/flags", flags_now(), 4'b0000);
    rst_n = 1'b1;
    tick();

    // ADD overflow into the sign bit.
    single("add", OP_ARITH, 8'h7F, 8'h01, 2'b00, 2'b00, 4'b0000, 8'h80, 4'b1100);
    tick();
    check("add/done_pulse", done, 1'b0);
    check("add/hold", result, 8'h80);

    // Preset C, then subtract with carry: cin = C ^ sub = 0.
    flag_din = 4'b0010; flag_wr = 1'b1;
    tick();
    flag_wr = 1'b0;
    check("flagwr/c", flags_now(), 4'b0010);
    single("subc", OP_ARITH, 8'h10, 8'h10, 2'b11, 2'b00, 4'b0000, 8'hFF, 4'b0110);

    single("swap", OP_LOGIC, 8'hA5, 8'h00, 2'b00, 2'b11, 4'b0000, 8'h5A, 4'b0010);
    single("xor",  OP_LOGIC, 8'h3C, 8'h3C, 2'b00, 2'b10, 4'b0000, 8'h00, 4'b0011);
    single("asr",  OP_SHIFT, 8'h81, 8'h00, 2'b00, 2'b00, 4'b1001, 8'hC0, 4'b0110);
    single("ror",  OP_SHIFT, 8'h01, 8'h00, 2'b00, 2'b00, 4'b0011, 8'h80, 4'b0110);
    single("rolc", OP_SHIFT, 8'h80, 8'h00, 2'b00, 2'b00, 4'b0110, 8'h01, 4'b0010);
    single("shl",  OP_SHIFT, 8'h40, 8'h00, 2'b00, 2'b00, 4'b0000, 8'h80, 4'b0100);

    // MUL 0xFF*0xFF with an ADD request at T+3 that must be ignored.
    issue(OP_MUL, 8'hFF, 8'hFF, 2'b00, 2'b00, 4'b0000);
    for (int k = 1; k <= W; k++) begin
      check("mul1/busy", busy, 1'b1);
      check("mul1/early_done", done, 1'b0);
      if (k == 3) begin
        op_type = OP_ARITH; operand1 = 8'h01; operand2 = 8'h01; arith_sel = 2'b00;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check("mul1/done", done, 1'b1);
    check("mul1/busy_end", busy, 1'b0);
    check("mul1/res", result, 8'h01);
    check("mul1/hi", result_hi, 8'hFE);
    check("mul1/flags", flags_now(), 4'b1110);
    flag_din = 4'b0101; flag_wr = 1'b1;
    tick();
    flag_wr = 1'b0;
    check("mul1/flagwr", flags_now(), 4'b0101);
    check("mul1/no_extra_done", done, 1'b0);
    check("mul1/hold", result, 8'h01);

    // MUL 0x0D*0x0B: flag writes while busy, one of them on the done edge.
    issue(OP_MUL, 8'h0D, 8'h0B, 2'b00, 2'b00, 4'b0000);
    for (int k = 1; k <= W; k++) begin
      check("mul2/busy", busy, 1'b1);
      if (k == 3) check("mul2/busy_flagwr", flags_now(), 4'b0001);
      if (k == 2) begin
        flag_din = 4'b0001; flag_wr = 1'b1;
      end else if (k == W) begin
        flag_din = 4'b1000; flag_wr = 1'b1;
      end else begin
        flag_wr = 1'b0;
      end
      tick();
    end
    flag_wr = 1'b0;
    check("mul2/done", done, 1'b1);
    check("mul2/res", result, 8'h8F);
    check("mul2/hi", result_hi, 8'h00);
    check("mul2/flag_prio", flags_now(), 4'b1000);
    // Back-to-back: new request accepted in the done cycle.
    single("b2b_move", OP_MOVE, 8'h00, 8'h33, 2'b00, 2'b00, 4'b0000, 8'h33, 4'b1000);

`ifdef ALU_SEQ_DIV_EN
    long_op("div", OP_DIV, 8'd200, 8'd7, 8'h1C, 8'h04, 4'b0000);
    long_op("div0", OP_DIV, 8'd200, 8'd0, 8'hFF, 8'hC8, 4'b1100);
    fl_after = 4'b1100;
`else
    single("div_rsv", OP_DIV, 8'd200, 8'd7, 2'b00, 2'b00, 4'b0000, 8'h00, 4'b1000);
    fl_after = 4'b1000;
`endif
    single("rsv110", 3'b110, 8'h12, 8'h34, 2'b00, 2'b00, 4'b0000, 8'h00, fl_after);

    // Reset in the middle of a MUL aborts it without a done.
    issue(OP_MUL, 8'h12, 8'h34, 2'b00, 2'b00, 4'b0000);
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("abort/busy", busy, 1'b0);
    check("abort/done", done, 1'b0);
    check("abort/res", result, 8'h00);
    check("abort/flags", flags_now(), 4'b0000);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 2 * W; k++) begin
      tick();
      seen = seen | done | busy;
    end
    check("abort/quiet", seen, 1'b0);
    flag_din = 4'b1111; flag_wr = 1'b1;
    tick();
    flag_wr = 1'b0;
    single("move", OP_MOVE, 8'hC3, 8'h5A, 2'b00, 2'b00, 4'b0000, 8'h5A, 4'b1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
